// File: rtl/secuenciador_pruebas.sv
// secuenciador_pruebas: burst loopback test sequencer for the register-mapped serial peripheral
module secuenciador_pruebas #(
  parameter int DATA_W  = 32,
  parameter int BYTE_W  = 8,
  parameter int N_BYTES = 4,
  parameter int TIMEOUT = 1024,
  parameter int ERR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boton_send,
  input  logic [BYTE_W-1:0] dato,
  input  logic              modo,
  input  logic [DATA_W-1:0] salida_o,
  output logic              wr_i,
  output logic              reg_sel_i,
  output logic              addr_i,
  output logic [DATA_W-1:0] entrada_i,
  output logic [BYTE_W-1:0] leds,
  output logic              ocupado,
  output logic              listo,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              timeout_flag
);
  localparam int KW = N_BYTES > 1 ? $clog2(N_BYTES) : 1;
  localparam int TW = $clog2(TIMEOUT + 1) + 1;
  typedef enum logic [2:0] {IDLE, WR_DATA, WR_CTRL, POLL_A, POLL_B, RD_A, RD_B, NEXT} state_t;
  state_t            state_q, state_d;
  logic              btn_q, btn_d;
  logic              modo_q, modo_d;
  logic              tflag_q, tflag_d;
  logic [BYTE_W-1:0] dato_q, dato_d, leds_q, leds_d, pay;
  logic [KW-1:0]     k_q, k_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [ERR_W-1:0]  err_q, err_d, err_inc;
  logic              arranque, last;
  assign btn_d    = boton_send;
  assign arranque = boton_send & ~btn_q;
  assign last     = k_q == KW'(N_BYTES - 1);
  assign pay      = dato_q + (modo_q ? BYTE_W'(k_q) : '0);
  assign err_inc  = &err_q ? err_q : err_q + ERR_W'(1);
  // next-state and datapath updates for the transfer sequence
  always_comb begin
    state_d = state_q;
    dato_d  = dato_q;
    modo_d  = modo_q;
    k_d     = k_q;
    tcnt_d  = tcnt_q;
    leds_d  = leds_q;
    err_d   = err_q;
    tflag_d = tflag_q;
    case (state_q)
      IDLE: if (arranque) begin
        state_d = WR_DATA;
        dato_d  = dato;
        modo_d  = modo;
        k_d     = '0;
        tflag_d = 1'b0;
      end
      WR_DATA: state_d = WR_CTRL;
      WR_CTRL: begin
        tcnt_d  = '0;
        state_d = POLL_A;
      end
      POLL_A: begin
        tcnt_d  = tcnt_q + TW'(1);
        state_d = POLL_B;
      end
      POLL_B: begin
        tcnt_d = tcnt_q + TW'(1);
        if (!salida_o[0]) state_d = RD_A;
        else if (tcnt_d >= TW'(TIMEOUT)) begin
          tflag_d = 1'b1;
          err_d   = err_inc;
          state_d = NEXT;
        end else state_d = POLL_A;
      end
      RD_A: state_d = RD_B;
      RD_B: begin
        leds_d  = salida_o[BYTE_W-1:0];
        err_d   = leds_d != pay ? err_inc : err_q;
        state_d = NEXT;
      end
      NEXT: begin
        state_d = last ? IDLE : WR_DATA;
        k_d     = last ? k_q : k_q + KW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      btn_q   <= 1'b0;
      dato_q  <= '0;
      modo_q  <= 1'b0;
      k_q     <= '0;
      tcnt_q  <= '0;
      leds_q  <= '0;
      err_q   <= '0;
      tflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= btn_d;
      dato_q  <= dato_d;
      modo_q  <= modo_d;
      k_q     <= k_d;
      tcnt_q  <= tcnt_d;
      leds_q  <= leds_d;
      err_q   <= err_d;
      tflag_q <= tflag_d;
    end
  end
  assign ocupado      = state_q != IDLE;
  assign listo        = state_q == NEXT && last;
  assign wr_i         = state_q == WR_DATA || state_q == WR_CTRL;
  assign reg_sel_i    = state_q == WR_DATA || state_q == RD_A || state_q == RD_B;
  assign addr_i       = state_q == RD_A || state_q == RD_B;
  assign entrada_i    = state_q == WR_DATA ? DATA_W'(pay) : state_q == WR_CTRL ? DATA_W'(1) : '0;
  assign leds         = leds_q;
  assign err_cnt      = err_q;
  assign timeout_flag = tflag_q;
endmodule

// File: doc/secuenciador_pruebas.md
# secuenciador_pruebas

Parametrised board-level test sequencer for the register-mapped serial peripheral. On each rising edge of `boton_send` it runs a burst of `N_BYTES` transfers. Each transfer writes a data byte to the peripheral, raises its send bit and polls until the peripheral clears that bit, with a timeout. It then reads back the received byte, shows it on `leds` and counts loopback mismatches. It replaces the single-shot generator in the FPGA top level, between the switches/button and the peripheral's `wr_i/reg_sel_i/addr_i/entrada_i/salida_o` port.

## Interface
Parameters:
- `DATA_W`, 32: peripheral bus width.
- `BYTE_W`, 8: payload width; must satisfy `BYTE_W <= DATA_W`.
- `N_BYTES`, 4: transfers per burst; must be ≥1.
- `TIMEOUT`, 1024: maximum cycles to wait for the send bit to clear; must be ≥2.
- `ERR_W`, 8: error counter width.

Ports:
- `clk`  in  1  system clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `boton_send`  in  1  debounced button level; a burst starts on its rising edge.
- `dato`  in  BYTE_W  base payload, latched at burst start.
- `modo`  in  1  latched at burst start; 0 = constant payload, 1 = incrementing payload.
- `salida_o`  in  DATA_W  peripheral read data; valid the cycle after the address is presented.
- `wr_i`  out  1  peripheral write strobe.
- `reg_sel_i`  out  1  0 = control register, 1 = data register.
- `addr_i`  out  1  0 = TX side, 1 = RX side.
- `entrada_i`  out  DATA_W  peripheral write data.
- `leds`  out  BYTE_W  last received byte.
- `ocupado`  out  1  high while a burst runs.
- `listo`  out  1  one-cycle pulse when a burst finishes.
- `err_cnt`  out  ERR_W  saturating count of mismatches plus timeouts.
- `timeout_flag`  out  1  sticky; set on any timeout; cleared at the next burst start.

## Operation
- Edge detect: `boton_send` is registered into `btn_q`; `arranque = boton_send & ~btn_q`.
- Payload for transfer k (k = 0..N_BYTES-1):
  - `modo = 0`: `dato_lat`.
  - `modo = 1`: `dato_lat + k`, modulo 2^BYTE_W (wraps, e.g. FE, FF, 00, 01).
  - Zero-extended to DATA_W on `entrada_i`.
- States:
  - IDLE: all strobes low. On `arranque`: latch `dato` and `modo`, set k=0, clear `timeout_flag`, go to WR_DATA.
  - WR_DATA (1 cycle): `wr_i=1`, `reg_sel_i=1`, `addr_i=0`, `entrada_i` = payload. Go to WR_CTRL.
  - WR_CTRL (1 cycle): `wr_i=1`, `reg_sel_i=0`, `addr_i=0`, `entrada_i=1` (send bit). Clear the timeout counter `tcnt`. Go to POLL_A.
  - POLL_A: `wr_i=0`, `reg_sel_i=0`, `addr_i=0`; `tcnt++`. Go to POLL_B.
  - POLL_B: same address; `tcnt++`.
    - If `salida_o[0]==0`, go to RD_A.
    - Else if `tcnt >= TIMEOUT`: set `timeout_flag`, `err_cnt++`, go to NEXT. No read happens and `leds` is unchanged.
    - Else go to POLL_A.
  - RD_A: `wr_i=0`, `reg_sel_i=1`, `addr_i=1`. Go to RD_B.
  - RD_B: same address. `leds <= salida_o[BYTE_W-1:0]`. If that value ≠ payload, `err_cnt++`. Go to NEXT.
  - NEXT: if k == N_BYTES-1, pulse `listo` and go to IDLE; else k++ and go to WR_DATA.
- `err_cnt` saturates at all-ones. It is never cleared except by `rst`, so it accumulates across bursts.
- `arranque` is ignored while `ocupado=1`. A button held high starts exactly one burst.
- `ocupado` is 1 in every state except IDLE.
- `entrada_i` is 0 in every state other than WR_DATA and WR_CTRL.

## Timing
- Reset values: `wr_i=0`, `reg_sel_i=0`, `addr_i=0`, `entrada_i=0`, `leds=0`, `ocupado=0`, `listo=0`, `err_cnt=0`, `timeout_flag=0`, state IDLE, `btn_q=0`.
- All outputs are registered or decoded from the registered state; none depend combinationally on `salida_o`.
- Start latency: a rising edge sampled at cycle t puts the block in WR_DATA at t+1.
- Per-transfer minimum is 7 cycles (WR_DATA, WR_CTRL, POLL_A, POLL_B, RD_A, RD_B, NEXT). Each extra poll round adds 2 cycles.
- A timeout is declared in the first POLL_B where `tcnt >= TIMEOUT`. That is at most TIMEOUT+1 cycles after WR_CTRL.
- `listo` is high for exactly the NEXT cycle of the final transfer. `ocupado` falls the following cycle.
- `rst` mid-burst takes effect the next edge: all outputs return to reset values and no partial write is issued afterwards.
- `dato` and `modo` changes during a burst have no effect.

## Test plan
- Loopback peripheral model (send bit clears 3 cycles after WR_CTRL, RX = TX), `N_BYTES=4`, `dato=0x41`, `modo=0`, one press → four WR_DATA writes of 0x41, `leds=0x41`, `err_cnt=0`, one `listo` pulse.
- `modo=1`, `dato=0xFE` → payloads FE, FF, 00, 01 in order; final `leds=0x01`.
- Peripheral never clears the send bit, `TIMEOUT=8` → each transfer aborts within 9 cycles of WR_CTRL with no RD_A; `timeout_flag=1`, `err_cnt=4`, `leds` unchanged.
- Model corrupts byte 2 (returns 0x00) → `err_cnt` increments by exactly 1; `leds` shows the last good byte.
- Button held high for 100 cycles plus a second press during the burst → exactly one burst, one `listo`.
- `rst` asserted in POLL_B of transfer 1 → next cycle all outputs are 0 and state is IDLE; a new press runs a clean burst.
